// File: rtl/micro_sequencer.sv
// micro_sequencer: Moore-FSM control unit that sequences fetch/execute micro-operations
// Ports:
//   clk, rst (async active-low)  clock and reset
//   cpustate[1:0]                00 stop, 01 single-step, 10 run, 11 stop
//   step                         async step button, rising edge used in single-step mode
//   dr[7:0], z                   data register (opcode at FETCH3) and ALU zero flag
//   read/write/membus/busmem     memory strobes
//   arload/arinc/pcload/pcinc/pcbus, drload/drlbus/drhbus/trload/trbus/irload  datapath controls
//   rload[3:0], rbus[3:0]        one-hot register load / bus enables
//   xload/yload/ybus/zload, alu_op[2:0]  ALU controls
//   halted, state_out[4:0]       status
module micro_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cpustate,
    input  logic       step,
    input  logic [7:0] dr,
    input  logic       z,
    output logic       read,
    output logic       write,
    output logic       membus,
    output logic       busmem,
    output logic       arload,
    output logic       arinc,
    output logic       pcload,
    output logic       pcinc,
    output logic       pcbus,
    output logic       drload,
    output logic       drlbus,
    output logic       drhbus,
    output logic       trload,
    output logic       trbus,
    output logic       irload,
    output logic [3:0] rload,
    output logic [3:0] rbus,
    output logic       xload,
    output logic       yload,
    output logic       ybus,
    output logic       zload,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic [4:0] state_out
);
    typedef enum logic [4:0] {
        IDLE, FETCH1, FETCH2, FETCH3, MOV1, ALU1, ALU2, ALU3, UN1, UN2,
        LD1, LD2, LD3, LD4, LD5, ST1, ST2, ST3, ST4, ST5,
        JMP1, JMP2, JMP3, JZN1, JZN2, HALT
    } state_t;

    state_t                 state, next;
    logic [7:0]             op;
    logic [SYNC_STAGES-1:0] sync;
    logic                   step_prev;
    logic                   step_edge;
    logic                   run;
    state_t                 eoi;
    logic [3:0]             sel_rd, sel_rs;

    assign run       = cpustate == 2'b10;
    assign eoi       = run ? FETCH1 : IDLE;
    assign step_edge = sync[SYNC_STAGES-1] & ~step_prev;
    assign sel_rd    = 4'b0001 << op[3:2];
    assign sel_rs    = 4'b0001 << op[1:0];
    assign state_out = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op        <= '0;
            sync      <= '0;
            step_prev <= 1'b0;
        end else begin
            state     <= next;
            op        <= (state == FETCH3) ? dr : op;
            sync      <= SYNC_STAGES'({sync, step});
            step_prev <= sync[SYNC_STAGES-1];
        end
    end

    // Edges are only looked at in IDLE, so any edge seen elsewhere is simply dropped.
    always_comb begin
        next = IDLE;
        case (state)
            IDLE:   next = (run || (cpustate == 2'b01 && step_edge)) ? FETCH1 : IDLE;
            FETCH3: begin
                case (dr[7:4])
                    4'h1:                      next = LD1;
                    4'h2:                      next = ST1;
                    4'h3:                      next = MOV1;
                    4'h4, 4'h5, 4'h6, 4'h7:    next = ALU1;
                    4'h8, 4'h9:                next = UN1;
                    4'hA:                      next = JMP1;
                    4'hB:                      next = z ? JMP1 : JZN1;
                    4'hF:                      next = HALT;
                    default:                   next = eoi;
                endcase
            end
            // Each multi-cycle chain is encoded consecutively in the enum.
            FETCH1, FETCH2, ALU1, ALU2, UN1, LD1, LD2, LD3, LD4,
            ST1, ST2, ST3, ST4, JMP1, JMP2, JZN1:
                    next = state_t'(state + 5'd1);
            MOV1, ALU3, UN2, LD5, ST5, JMP3, JZN2:
                    next = eoi;
            HALT:   next = HALT;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        read = 1'b0; write = 1'b0; membus = 1'b0; busmem = 1'b0;
        arload = 1'b0; arinc = 1'b0; pcload = 1'b0; pcinc = 1'b0; pcbus = 1'b0;
        drload = 1'b0; drlbus = 1'b0; drhbus = 1'b0; trload = 1'b0; trbus = 1'b0; irload = 1'b0;
        rload = 4'b0; rbus = 4'b0;
        xload = 1'b0; yload = 1'b0; ybus = 1'b0; zload = 1'b0; alu_op = 3'b0;
        halted = 1'b0;
        case (state)
            FETCH1: begin pcbus = 1'b1; arload = 1'b1; end
            FETCH2: begin read = 1'b1; membus = 1'b1; drload = 1'b1; pcinc = 1'b1; end
            FETCH3: begin irload = 1'b1; pcbus = 1'b1; arload = 1'b1; end
            MOV1:   begin rbus = sel_rs; rload = sel_rd; end
            ALU1:   begin rbus = sel_rs; xload = 1'b1; end
            // ADD..OR map to 000..011 and INC/NOT to 100/101, all as opcode-4.
            ALU2, UN1: begin rbus = sel_rd; yload = 1'b1; zload = 1'b1; alu_op = 3'(op[7:4] - 4'd4); end
            ALU3, UN2: begin ybus = 1'b1; rload = sel_rd; end
            LD1, ST1: begin read = 1'b1; membus = 1'b1; drload = 1'b1; pcinc = 1'b1; arinc = 1'b1; end
            LD2, ST2: begin trload = 1'b1; read = 1'b1; membus = 1'b1; drload = 1'b1; pcinc = 1'b1; end
            LD3, ST3: begin drhbus = 1'b1; trbus = 1'b1; arload = 1'b1; end
            LD4:    begin read = 1'b1; membus = 1'b1; drload = 1'b1; end
            LD5:    begin drlbus = 1'b1; rload = 4'b0001; end
            ST4:    begin rbus = 4'b0001; drload = 1'b1; end
            ST5:    begin write = 1'b1; busmem = 1'b1; drlbus = 1'b1; end
            JMP1:   begin read = 1'b1; membus = 1'b1; drload = 1'b1; arinc = 1'b1; end
            JMP2:   begin trload = 1'b1; read = 1'b1; membus = 1'b1; drload = 1'b1; end
            JMP3:   begin drhbus = 1'b1; trbus = 1'b1; pcload = 1'b1; end
            JZN1:   begin pcinc = 1'b1; arinc = 1'b1; end
            JZN2:   pcinc = 1'b1;
            HALT:   halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: randomized scoreboard bench with an instruction-level reference model
module tb_micro_sequencer;
    localparam int S = 2;
    typedef logic [30:0] bun_t;

    localparam bun_t READ   = bun_t'(1) << 0,  WRITE  = bun_t'(1) << 1,  MEMBUS = bun_t'(1) << 2;
    localparam bun_t BUSMEM = bun_t'(1) << 3,  ARLOAD = bun_t'(1) << 4,  ARINC  = bun_t'(1) << 5;
    localparam bun_t PCLOAD = bun_t'(1) << 6,  PCINC  = bun_t'(1) << 7,  PCBUS  = bun_t'(1) << 8;
    localparam bun_t DRLOAD = bun_t'(1) << 9,  DRLBUS = bun_t'(1) << 10, DRHBUS = bun_t'(1) << 11;
    localparam bun_t TRLOAD = bun_t'(1) << 12, TRBUS  = bun_t'(1) << 13, IRLOAD = bun_t'(1) << 14;
    localparam bun_t XLOAD  = bun_t'(1) << 15, YLOAD  = bun_t'(1) << 16, YBUS   = bun_t'(1) << 17;
    localparam bun_t ZLOAD  = bun_t'(1) << 18, HALTB  = bun_t'(1) << 19;

    localparam bun_t F1 = PCBUS | ARLOAD;
    localparam bun_t F2 = READ | MEMBUS | DRLOAD | PCINC;
    localparam bun_t F3 = IRLOAD | PCBUS | ARLOAD;
    localparam bun_t M1 = READ | MEMBUS | DRLOAD | PCINC | ARINC;
    localparam bun_t M2 = TRLOAD | READ | MEMBUS | DRLOAD | PCINC;
    localparam bun_t M3 = DRHBUS | TRBUS | ARLOAD;

    logic clk = 1'b0, rst = 1'b0, step = 1'b0, z = 1'b0;
    logic [1:0] cpustate = 2'b00;
    logic [7:0] dr = 8'h00;
    logic read, write, membus, busmem, arload, arinc, pcload, pcinc, pcbus;
    logic drload, drlbus, drhbus, trload, trbus, irload, xload, yload, ybus, zload, halted;
    logic [3:0] rload, rbus;
    logic [2:0] alu_op;
    logic [4:0] state_out, idle_code;

    int vectors = 0, errors = 0;

    micro_sequencer #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .cpustate(cpustate), .step(step), .dr(dr), .z(z),
        .read(read), .write(write), .membus(membus), .busmem(busmem),
        .arload(arload), .arinc(arinc), .pcload(pcload), .pcinc(pcinc), .pcbus(pcbus),
        .drload(drload), .drlbus(drlbus), .drhbus(drhbus), .trload(trload), .trbus(trbus),
        .irload(irload), .rload(rload), .rbus(rbus), .xload(xload), .yload(yload),
        .ybus(ybus), .zload(zload), .alu_op(alu_op), .halted(halted), .state_out(state_out)
    );

    always #5 clk = ~clk;

    function automatic bun_t rl(input int n); return bun_t'(1) << (23 + n); endfunction
    function automatic bun_t rb(input int n); return bun_t'(1) << (27 + n); endfunction
    function automatic bun_t alu(input int v); return bun_t'(v) << 20; endfunction

    function automatic bun_t dut_bun();
        return {rbus, rload, alu_op, halted, zload, ybus, yload, xload, irload, trbus, trload,
                drhbus, drlbus, drload, pcbus, pcinc, pcload, arinc, arload, busmem, membus, write, read};
    endfunction

    // Reference model: each instruction expands into its list of per-cycle strobe sets.
    bun_t uq[$];
    bun_t sb[$];
    bun_t m_cur = '0;
    int   phase = 0;
    bit   m_halt = 1'b0;
    logic [S:0] hist = '0;

    task automatic build_body(input logic [7:0] d, input logic zf);
        int opc, rd, rs;
        opc = int'(d[7:4]); rd = int'(d[3:2]); rs = int'(d[1:0]);
        case (opc)
            1: begin uq.push_back(M1); uq.push_back(M2); uq.push_back(M3);
                     uq.push_back(READ | MEMBUS | DRLOAD); uq.push_back(DRLBUS | rl(0)); end
            2: begin uq.push_back(M1); uq.push_back(M2); uq.push_back(M3);
                     uq.push_back(rb(0) | DRLOAD); uq.push_back(WRITE | BUSMEM | DRLBUS); end
            3: uq.push_back(rb(rs) | rl(rd));
            4, 5, 6, 7: begin uq.push_back(rb(rs) | XLOAD);
                     uq.push_back(rb(rd) | YLOAD | ZLOAD | alu(opc - 4));
                     uq.push_back(YBUS | rl(rd)); end
            8, 9: begin uq.push_back(rb(rd) | YLOAD | ZLOAD | alu(opc == 8 ? 4 : 5));
                     uq.push_back(YBUS | rl(rd)); end
            10, 11: begin
                if (opc == 10 || zf) begin
                    uq.push_back(READ | MEMBUS | DRLOAD | ARINC);
                    uq.push_back(TRLOAD | READ | MEMBUS | DRLOAD);
                    uq.push_back(DRHBUS | TRBUS | PCLOAD);
                end else begin
                    uq.push_back(PCINC | ARINC); uq.push_back(PCINC);
                end
            end
            15: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    task automatic model_edge();
        bit ev, go;
        ev = hist[S-1] & ~hist[S];
        hist = {hist[S-1:0], step};
        if (!m_halt && uq.size() == 0) begin
            go = 1'b0;
            if (phase == 0) go = cpustate == 2'b10 || (cpustate == 2'b01 && ev);
            else begin
                if (phase == 1) begin build_body(dr, z); phase = 2; end
                if (uq.size() == 0 && !m_halt) begin
                    go = cpustate == 2'b10;
                    if (!go) phase = 0;
                end
            end
            if (go) begin uq.push_back(F1); uq.push_back(F2); uq.push_back(F3); phase = 1; end
        end
        m_cur = m_halt ? HALTB : (uq.size() > 0 ? uq.pop_front() : '0);
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            uq.delete(); phase = 0; m_halt = 1'b0; hist = '0; m_cur = '0;
        end else model_edge();
        sb.push_back(m_cur);
    end

    bun_t exp_b, act_b;
    int   nbus;
    always @(negedge clk) begin
        vectors++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got an output cycle with no expected entry");
        end else begin
            exp_b = sb.pop_front();
            act_b = dut_bun();
            if (act_b !== exp_b) begin
                errors++;
                $display("FAIL outputs @%0t: got %h expected %h", $time, act_b, exp_b);
            end
        end
        vectors++;
        nbus = $countones({pcbus, drlbus, drhbus, trbus, membus, ybus, rbus});
        if (!(nbus <= 1 || (nbus == 2 && drhbus && trbus))) begin
            errors++;
            $display("FAIL bus_exclusive @%0t: %0d drivers, required at most 1", $time, nbus);
        end
        if (phase == 0 && !m_halt) begin
            vectors++;
            if (state_out !== idle_code) begin
                errors++;
                $display("FAIL state_out_idle @%0t: got %h expected %h", $time, state_out, idle_code);
            end
        end
    end

    task automatic rand_inputs(input bit allow_halt);
        int r;
        if ($urandom_range(0, 19) == 0) begin
            r = $urandom_range(0, 9);
            cpustate = r < 6 ? 2'b10 : r < 8 ? 2'b01 : r < 9 ? 2'b00 : 2'b11;
        end
        dr = {4'($urandom_range(0, allow_halt ? 15 : 14)), 4'($urandom)};
        z = 1'($urandom);
        if ($urandom_range(0, 3) == 0) step = ~step;
    endtask

    initial begin
        logic [7:0] ops [12];
        bit found;
        ops = '{8'h12, 8'h2C, 8'h3B, 8'h5E, 8'h6D, 8'h7F, 8'h8C, 8'h9D, 8'hA0, 8'hC0, 8'hD0, 8'hE0};
        #1;
        vectors++;
        if (dut_bun() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", dut_bun());
        end
        idle_code = state_out;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cpustate = 2'b10; dr = 8'h00;
        repeat (30) @(negedge clk);
        dr = 8'h46;
        repeat (20) @(negedge clk);
        dr = 8'hB5; z = 1'b0;
        repeat (20) @(negedge clk);
        z = 1'b1;
        repeat (20) @(negedge clk);
        foreach (ops[i]) begin
            dr = ops[i];
            repeat (12) @(negedge clk);
        end
        cpustate = 2'b01; dr = 8'h00;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            repeat (2) @(negedge clk);
            step = 1'b0;
            repeat (15) @(negedge clk);
        end
        step = 1'b1;
        repeat (2) @(negedge clk);
        step = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (m_cur == F1) found = 1'b1;
        end
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        repeat (15) @(negedge clk);
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            rand_inputs(1'b0);
        end
        cpustate = 2'b10; dr = 8'h10;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (m_cur == M3) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL reach_ld3: LD3 not reached within 60 cycles");
        end
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (dut_bun() !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", dut_bun());
        end
        cpustate = 2'b00;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (10) @(negedge clk);
        cpustate = 2'b10; dr = 8'hF0;
        for (int i = 0; i < 20 && !m_halt; i++) @(negedge clk);
        vectors++;
        if (!m_halt) begin
            errors++;
            $display("FAIL reach_halt: HALT not reached within 20 cycles");
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rand_inputs(1'b1);
            cpustate = 2'($urandom);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_sticky: got %b expected 1", halted);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the number of synchronizer flops on `step`.
REQ-002 `clk`  in  1  system clock; all state changes occur on its rising edge.
REQ-003 `rst`  in  1  asynchronous, active-low reset.
REQ-004 `cpustate`  in  2  run mode: 00 stop, 01 single-step, 10 run, 11 is treated as stop.
REQ-005 `step`  in  1  asynchronous step button; only its synchronized rising edge is used.
REQ-006 `dr`  in  8  current DR contents; the opcode byte during FETCH3.
REQ-007 `z`  in  1  ALU zero flag.
REQ-008 `read`, `write`, `membus`, `busmem`  out  1 each  memory strobes.
REQ-009 `arload`, `arinc`, `pcload`, `pcinc`, `pcbus`  out  1 each  AR/PC controls.
REQ-010 `drload`, `drlbus`, `drhbus`, `trload`, `trbus`, `irload`  out  1 each  DR/TR/IR controls.
REQ-011 `rload`, `rbus`  out  4 each  one-hot general-register load and bus enables, bit n selects Rn.
REQ-012 `xload`, `yload`, `ybus`, `zload`  out  1 each  ALU operand, result and flag controls.
REQ-013 `alu_op`  out  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 100 inc, 101 not.
REQ-014 `halted`  out  1  high while in HALT.
REQ-015 `state_out`  out  5  current state encoding, for the display.

Function
REQ-016 The block SHALL be a Moore FSM: all control outputs are decoded from the current state and the latched opcode register `op[7:0]` only.
REQ-017 The states SHALL be IDLE, FETCH1-3, MOV1, ALU1-3, UN1-2, LD1-5, ST1-5, JMP1-3, JZN1-2 and HALT.
REQ-018 IDLE SHALL assert no strobes. It goes to FETCH1 when `cpustate`=10, or when `cpustate`=01 and a synchronized step edge occurs; otherwise it stays in IDLE.
REQ-019 FETCH1 SHALL assert `pcbus` and `arload`.
REQ-020 FETCH2 SHALL assert `read`, `membus`, `drload` and `pcinc`.
REQ-021 FETCH3 SHALL assert `irload`, `pcbus` and `arload`, and SHALL capture `dr` into `op` on the same edge.
REQ-022 The next state after FETCH3 SHALL be selected from `dr[7:4]`, not from `op`.
REQ-023 Opcode 0000 (NOP), and the undefined opcodes 1100-1110, SHALL go directly to end-of-instruction.
REQ-024 Opcode 0011 (MOV rd,rs): MOV1 asserts `rbus[op[1:0]]` and `rload[op[3:2]]`.
REQ-025 Opcodes 0100-0111 (ADD, SUB, AND, OR): ALU1 asserts `rbus[rs]` and `xload`. ALU2 asserts `rbus[rd]`, `yload`, `zload` and `alu_op`=opcode-4. ALU3 asserts `ybus` and `rload[rd]`.
REQ-026 Opcodes 1000 (INC) and 1001 (NOT): UN1 asserts `rbus[rd]`, `yload`, `zload` and `alu_op`=100 or 101 respectively. UN2 asserts `ybus` and `rload[rd]`.
REQ-027 Opcode 0001 (LDAC addr, load into R0):
- LD1: `read`, `membus`, `drload`, `pcinc`, `arinc`.
- LD2: `trload`, `read`, `membus`, `drload`, `pcinc`.
- LD3: `drhbus`, `trbus`, `arload`.
- LD4: `read`, `membus`, `drload`.
- LD5: `drlbus`, `rload[0]`.
REQ-028 Opcode 0010 (STAC addr): ST1-ST3 are identical to LD1-LD3. ST4 asserts `rbus[0]` and `drload`. ST5 asserts `write`, `busmem` and `drlbus`.
REQ-029 Opcode 1010 (JUMP):
- JMP1: `read`, `membus`, `drload`, `arinc`.
- JMP2: `trload`, `read`, `membus`, `drload`.
- JMP3: `drhbus`, `trbus`, `pcload`.
REQ-030 Opcode 1011 (JMPZ): with `z`=1 at FETCH3 it follows JMP1-3. With `z`=0 it runs JZN1 (`pcinc`, `arinc`) then JZN2 (`pcinc`).
REQ-031 Opcode 1111 (HALT) SHALL enter HALT, which asserts `halted`, asserts no strobes, and is left only by reset.
REQ-032 End-of-instruction SHALL go to FETCH1 if `cpustate`=10, else to IDLE. A mode change mid-instruction never aborts the instruction.
REQ-033 The step edge detector SHALL consume one edge per instruction. An edge that occurs outside IDLE is discarded.
REQ-034 At most one of `pcbus`, `drlbus`, `drhbus`, `trbus`, `membus`, `ybus` and the `rbus` bits SHALL be high in any state, except the drhbus+trbus pair, which drive split address halves.

Reset
REQ-035 While `rst`=0, the block SHALL immediately force state IDLE, `op`=00, the synchronizer and edge detector to 0, and every output to 0 (`state_out`=IDLE code, `halted`=0).
REQ-036 After `rst` deasserts, the first FETCH1 SHALL occur on the first clock edge at which the REQ-018 conditions hold.

Verification
REQ-037 Reset, `cpustate`=10, `dr`=00 forever -> repeating FETCH1/2/3 with the exact strobes of REQ-019 to REQ-021, and `pcinc` once per 3 cycles.
REQ-038 `cpustate`=10, `dr`=0x46 (ADD R1,R2) at FETCH3 -> ALU1 `rbus`=0100 `xload`; ALU2 `rbus`=0010 `alu_op`=000; ALU3 `ybus` `rload`=0010; then FETCH1.
REQ-039 JMPZ with `z`=0 -> exactly 2 extra cycles with `pcinc` high in both. JMPZ with `z`=1 -> JMP3 asserts `pcload`.
REQ-040 `cpustate`=01, 3 step edges, NOP stream -> exactly 3 FETCH sequences, IDLE between them. A step pulse during FETCH2 is ignored.
REQ-041 `rst` pulled low during LD3 -> all outputs 0 asynchronously, before the next edge. After release with `cpustate`=00, the block stays in IDLE.
REQ-042 `dr`=0xF0 at FETCH3 -> HALT with `halted`=1 indefinitely, regardless of `cpustate` or `step`.
